fir_coef_ctrl: RTL

Sequencing and configuration controller for the 16-tap symmetric FIR (8 unique signed 16-bit coefficients, en-strobed input, fixed pipeline).
- Owns a shadow coefficient bank, written by the host, and an active bank, which drives the FIR coef_0..coef_7 inputs.
- Gates the sample stream into the FIR and swaps shadow into active only after the FIR pipeline has drained, so no output sample mixes two coefficient sets.

---
 rtl/fir_coef_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fir_coef_ctrl.sv
// rtl/fir_coef_ctrl.sv - shadow/active coefficient bank controller with drain-gated swap for a 16-tap symmetric FIR
module fir_coef_ctrl #(
    parameter int DW       = 16,
    parameter int PIPE_LAT = 4,
    parameter int NTAP     = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          fir_en,
    output logic [DW-1:0] fir_xin,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    output logic          cfg_ready,
    input  logic          cfg_commit,
    input  logic          cfg_rd,
    output logic [DW-1:0] cfg_rdata,
    output logic          cfg_done,
    output logic          cfg_err,
    output logic          busy,
    output logic [DW-1:0] coef_0,
    output logic [DW-1:0] coef_1,
    output logic [DW-1:0] coef_2,
    output logic [DW-1:0] coef_3,
    output logic [DW-1:0] coef_4,
    output logic [DW-1:0] coef_5,
    output logic [DW-1:0] coef_6,
    output logic [DW-1:0] coef_7
);

    localparam int CW = $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SWAP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_d;
    logic            s_ready_q;
    logic            cfg_ready_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            fir_en_q;
    logic [DW-1:0]   fir_xin_q;
    logic [DW-1:0]   rdata_q;
    logic [DW-1:0]   shadow_q [NTAP];
    logic [DW-1:0]   active_q [NTAP];
    logic            accept;
    logic            wr_ok;

    // Ready flags are registered, so both handshakes use the registered view
    assign accept = s_valid && s_ready_q;
    assign wr_ok  = cfg_we && cfg_ready_q;

    // State register and drain counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, drain counter update and commit rejection
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        if (accept) begin
            cnt_d = CW'(PIPE_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        case (state_q)
            IDLE: begin
                if (cfg_commit) state_d = HOLD;
            end
            HOLD: begin
                if (cfg_commit) err_d = 1'b1;
                if (cnt_q == '0 && !accept) state_d = SWAP;
            end
            SWAP: begin
                if (cfg_commit) err_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_ready_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            s_ready_q   <= (state_d == IDLE);
            cfg_ready_q <= (state_d != SWAP);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_q == SWAP);
            err_q       <= err_d;
        end
    end

    // Sample path: one-cycle strobe, sample held between accepts
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fir_en_q  <= 1'b0;
            fir_xin_q <= '0;
        end else begin
            fir_en_q <= accept;
            if (accept) fir_xin_q <= s_data;
        end
    end

    // Shadow bank: host writes, dropped while swapping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NTAP; i++) shadow_q[i] <= '0;
        end else if (wr_ok) begin
            shadow_q[cfg_addr] <= cfg_wdata;
        end
    end

    // Active bank: whole-bank copy on the single SWAP edge only
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NTAP; i++) active_q[i] <= '0;
        end else if (state_q == SWAP) begin
            for (int i = 0; i < NTAP; i++) active_q[i] <= shadow_q[i];
        end
    end

    // Readback of the active bank, held when not strobed
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (cfg_rd) begin
            rdata_q <= active_q[cfg_addr];
        end
    end

    assign s_ready   = s_ready_q;
    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign fir_en    = fir_en_q;
    assign fir_xin   = fir_xin_q;
    assign cfg_rdata = rdata_q;
    assign coef_0    = active_q[0];
    assign coef_1    = active_q[1];
    assign coef_2    = active_q[2];
    assign coef_3    = active_q[3];
    assign coef_4    = active_q[4];
    assign coef_5    = active_q[5];
    assign coef_6    = active_q[6];
    assign coef_7    = active_q[7];

endmodule
